sid_regbank: RTL

Parametrised bank of host-writable configuration registers on the Zorro III slave data path, generalising the single SCSI-ID/option byte to `NREG` registers of `DW` bits with byte-lane strobes and address decode. Sits behind the address decoder, which asserts `reg_cycle` for the bank's window. Provides a registered read path, a single `dtack` pulse per bus cycle, and all register contents in parallel to the SCSI option logic.

---
 rtl/sid_regbank_pkg.sv | 33 +++
 rtl/sid_lane_reg.sv | 35 +++
 rtl/sid_regbank.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sid_regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sid_regbank_pkg
// Description : Shared types and constants for the SCSI-ID register bank.
// Revision    : 1.0 - initial release
// ============================================================================
package sid_regbank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } sid_state_t;

    localparam logic [7:0] SID_DEFAULT  = 8'hFF;
    localparam int         SID_LOCK_BIT = 7;
    localparam int         SID_MAX_BITS = 256;

    // Byte-wise fill so every register comes up as the legacy SCSI default.
    function automatic logic [SID_MAX_BITS-1:0] sid_all_ones(input int nbits);
        logic [SID_MAX_BITS-1:0] v;
        v = '0;
        for (int b = 0; b < SID_MAX_BITS / 8; b++) begin
            if (b * 8 < nbits) begin
                v[b*8 +: 8] = SID_DEFAULT;
            end
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sid_lane_reg.sv
`default_nettype none
// ============================================================================
// Module      : sid_lane_reg
// Description : One DW-bit register with per-byte-lane write enables.
// Revision    : 1.0 - initial release
// ============================================================================
module sid_lane_reg #(
    parameter int            DW        = 8,
    parameter logic [DW-1:0] RESET_VAL = '1
) (
    input  logic            clk,
    input  logic            IORST_n,
    input  logic [DW/8-1:0] i_we,
    input  logic [DW-1:0]   i_d,
    output logic [DW-1:0]   o_q
);

    logic [DW-1:0] r_q;

    always_ff @(posedge clk or negedge IORST_n) begin
        if (!IORST_n) begin
            r_q <= RESET_VAL;
        end else begin
            for (int l = 0; l < DW / 8; l++) begin
                if (i_we[l]) begin
                    r_q[l*8 +: 8] <= i_d[l*8 +: 8];
                end
            end
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/sid_regbank.sv
`default_nettype none
// ============================================================================
// Module      : sid_regbank
// Description : Host-writable configuration register bank on the Zorro III
//               slave path. Define SID_REGBANK_LOCK_EN for the sticky lock.
// Revision    : 1.0 - initial release
// ============================================================================
module sid_regbank
    import sid_regbank_pkg::*;
#(
    parameter int                 NREG      = 4,
    parameter int                 AW        = 2,
    parameter int                 DW        = 8,
    parameter logic [NREG*DW-1:0] RESET_VAL = (NREG*DW)'(sid_all_ones(NREG*DW))
) (
    input  logic               clk,
    input  logic               IORST_n,
    input  logic               reg_cycle,
    input  logic               DOE,
    input  logic [DW/8-1:0]    DS_n,
    input  logic               READ,
    input  logic [AW-1:0]      ADDR,
    input  logic [DW-1:0]      DIN,
    output logic [DW-1:0]      DOUT,
    output logic               rd_valid,
    output logic               dtack,
    output logic [NREG*DW-1:0] cfg_out
);

    localparam int LANES = DW / 8;

    sid_state_t    r_state;
    logic [DW-1:0] r_dout;
    logic          r_rd_valid;
    logic          r_dtack;

    logic             w_ds_any;
    logic             w_strobe;
    logic             w_wr_go;
    logic             w_locked;
    logic [DW-1:0]    w_rd_data;
    logic [LANES-1:0] w_we [NREG];
    logic [DW-1:0]    w_q  [NREG];

    assign w_ds_any = (DS_n != '1);
    assign w_strobe = reg_cycle && DOE && w_ds_any;
    assign w_wr_go  = (r_state == ST_IDLE) && w_strobe && !READ && !w_locked;

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        assign w_we[i] = (w_wr_go && (ADDR == AW'(i))) ? ~DS_n : '0;

        sid_lane_reg #(
            .DW        (DW),
            .RESET_VAL (RESET_VAL[i*DW +: DW])
        ) u_reg (
            .clk     (clk),
            .IORST_n (IORST_n),
            .i_we    (w_we[i]),
            .i_d     (DIN),
            .o_q     (w_q[i])
        );

        assign cfg_out[i*DW +: DW] = w_q[i];
    end

    // Unmatched addresses (ADDR >= NREG) fall through to all ones.
    always_comb begin
        w_rd_data = '1;
        for (int i = 0; i < NREG; i++) begin
            if (ADDR == AW'(i)) begin
                w_rd_data = w_q[i];
            end
        end
    end

`ifdef SID_REGBANK_LOCK_EN
    logic r_lock;

    // Set only by an accepted write; the reset-time ones do not lock the bank.
    always_ff @(posedge clk or negedge IORST_n) begin
        if (!IORST_n) begin
            r_lock <= 1'b0;
        end else if (w_we[NREG-1][SID_LOCK_BIT/8] && DIN[SID_LOCK_BIT]) begin
            r_lock <= 1'b1;
        end
    end

    assign w_locked = r_lock;
`else
    assign w_locked = 1'b0;
`endif

    always_ff @(posedge clk or negedge IORST_n) begin
        if (!IORST_n) begin
            r_state    <= ST_IDLE;
            r_dout     <= '1;
            r_rd_valid <= 1'b0;
            r_dtack    <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_dtack    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_strobe) begin
                        if (READ) begin
                            r_dout     <= w_rd_data;
                            r_rd_valid <= 1'b1;
                            r_state    <= ST_RD;
                        end else begin
                            r_dtack    <= 1'b1;
                            r_state    <= ST_ACK;
                        end
                    end
                end
                ST_RD: begin
                    r_dtack <= 1'b1;
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Wait for the host to drop the strobes so one bus cycle yields one dtack.
                    if (!(reg_cycle && w_ds_any)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign DOUT     = r_dout;
    assign rd_valid = r_rd_valid;
    assign dtack    = r_dtack;

endmodule
`default_nettype wire
